alu_op_sequencer: RTL

Initiator side of the ALU datapath interface. It accepts one operation request at a time, drives the ALU's Y, B and op inputs from internal registers, and holds them stable for an op-dependent settle time. It then captures the 64-bit ALU result C into the Z register pair (z_hi/z_lo) and presents it on a valid/ready response port. It sits between the control unit and the combinational ALU, replacing ad-hoc Yin/Zin strobing.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_latency.sv | 39 +++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and sequencer state constants for the ALU datapath
//
// Purpose: opcode values understood by the combinational ALU, the last legal
//          opcode, and the sequencer state encoding.
// Ports:   none (package)
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_AND    = 4'd0;
  localparam opcode_t OP_OR     = 4'd1;
  localparam opcode_t OP_NEGATE = 4'd2;
  localparam opcode_t OP_NOT    = 4'd3;
  localparam opcode_t OP_ADD    = 4'd4;
  localparam opcode_t OP_SUB    = 4'd5;
  localparam opcode_t OP_MUL    = 4'd6;
  localparam opcode_t OP_DIV    = 4'd7;
  localparam opcode_t OP_SHR    = 4'd8;
  localparam opcode_t OP_SHRA   = 4'd9;
  localparam opcode_t OP_SHL    = 4'd10;
  localparam opcode_t OP_ROR    = 4'd11;
  localparam opcode_t OP_ROL    = 4'd12;
  localparam opcode_t OP_LAST   = OP_ROL;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_op_latency.sv
// rtl/alu_op_latency.sv - opcode legality and settle-count lookup
//
// Purpose: combinational decode of an opcode into a legal flag and the
//          number of settle cycles minus one, ready to load into the
//          sequencer's down-counter.
// Ports:
//   op     in  4       opcode
//   legal  out 1       opcode is 0..OP_LAST
//   cnt    out CNT_W   settle cycles - 1 (0 for illegal opcodes)
module alu_op_latency
  import alu_pkg::*;
#(
  parameter int BASIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8,
  parameter int CNT_W        = 4
) (
  input  logic [3:0]       op,
  output logic             legal,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] BASIC_M1 = CNT_W'(BASIC_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_M1   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV_CYCLES - 1);

  always_comb begin
    legal = (op <= OP_LAST);
    cnt   = '0;
    if (op == OP_MUL) begin
      cnt = MUL_M1;
    end else if (op == OP_DIV) begin
      cnt = DIV_M1;
    end else if (op <= OP_LAST) begin
      cnt = BASIC_M1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer driving the combinational ALU
//
// Purpose: accepts one operation at a time, holds the ALU inputs stable for
//          the opcode's settle time, captures the 64-bit result into the Z
//          register pair and offers it on a valid/ready response port.
// Ports:
//   clock      in  1   rising-edge clock
//   clear      in  1   asynchronous active-high reset
//   req_valid  in  1   request present
//   req_ready  out 1   sequencer idle, request will be taken
//   req_op     in  4   opcode
//   req_a      in  32  first operand (ALU A/Y)
//   req_b      in  32  second operand (ALU B)
//   alu_y      out 32  to ALU A/Y inputs
//   alu_b      out 32  to ALU B input
//   alu_op     out 4   to ALU op input
//   alu_c      in  64  ALU result
//   z_hi       out 32  captured result [63:32]
//   z_lo       out 32  captured result [31:0]
//   rsp_valid  out 1   result available
//   rsp_ready  in  1   consumer takes result
//   rsp_err    out 1   last request carried an illegal opcode
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int BASIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [63:0] alu_c,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_legal;
  logic [CNT_W-1:0] op_cnt;

  alu_op_latency #(
    .BASIC_CYCLES(BASIC_CYCLES),
    .MUL_CYCLES  (MUL_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_latency (
    .op   (req_op),
    .legal(op_legal),
    .cnt  (op_cnt)
  );

  // Handshake flags are pure state decodes so they fall to their reset
  // values the instant clear is asserted.
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      alu_y   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      z_hi    <= '0;
      z_lo    <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_y  <= req_a;
            alu_b  <= req_b;
            alu_op <= req_op;
            if (op_legal) begin
              cnt   <= op_cnt;
              state <= ST_EXEC;
            end else begin
              // Illegal opcodes skip the ALU entirely and answer at once.
              z_hi    <= '0;
              z_lo    <= '0;
              rsp_err <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end

        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Only this edge looks at alu_c; the ALU has settled by now.
            z_hi    <= alu_c[63:32];
            z_lo    <= alu_c[31:0];
            rsp_err <= 1'b0;
            state   <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
